// File: rtl/nios2_subsystem_fifo_ctrl_pkg.sv
// rtl/nios2_subsystem_fifo_ctrl_pkg.sv - register map, bit positions and prefetch FSM encoding
package nios2_subsystem_fifo_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DROP    = 2'd3;

  localparam int STAT_VALID_BIT    = 0;
  localparam int STAT_EMPTY_BIT    = 1;
  localparam int STAT_FULL_BIT     = 2;
  localparam int STAT_UNDERRUN_BIT = 3;
  localparam int STAT_OVERFLOW_BIT = 4;
  localparam int STAT_FLUSH_BIT    = 5;
  localparam int STAT_USEDW_LSB    = 16;

  localparam int CTL_IRQ_EN_BIT    = 0;
  localparam int CTL_FLUSH_BIT     = 1;
  localparam int CTL_THRESH_LSB    = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_FLUSH = 2'd3
  } pf_state_t;

endpackage

// File: rtl/nios2_subsystem_fifo_prefetch.sv
// rtl/nios2_subsystem_fifo_prefetch.sv - one-entry prefetch of a normal-mode scfifo
// Pops the FIFO ahead of the CPU so DATA reads always hit a registered word.
module nios2_subsystem_fifo_prefetch
  import nios2_subsystem_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  input  logic              data_read,
  input  logic              flush_start,
  output logic              fifo_rdreq,
  output logic [DATA_W-1:0] prefetch,
  output logic              valid,
  output pf_state_t         state
);

  pf_state_t next_state;
  logic      valid_next;
  logic      load;
  logic      rdreq_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      prefetch   <= '0;
      valid      <= 1'b0;
      rdreq_last <= 1'b0;
    end else begin
      state      <= next_state;
      valid      <= valid_next;
      rdreq_last <= fifo_rdreq;
      if (load) prefetch <= fifo_q;
    end
  end

  always_comb begin
    next_state = state;
    valid_next = valid;
    fifo_rdreq = 1'b0;
    load       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load       = 1'b1;
        valid_next = 1'b1;
        next_state = ST_VALID;
      end
      ST_VALID: begin
        if (data_read) begin
          if (!fifo_empty) begin
            fifo_rdreq = 1'b1;
            next_state = ST_FETCH;
          end else begin
            valid_next = 1'b0;
            next_state = ST_EMPTY;
          end
        end
      end
      ST_FLUSH: begin
        valid_next = 1'b0;
        fifo_rdreq = !fifo_empty;
        // q of the last pop lands one cycle later; wait it out before leaving
        if (fifo_empty && !rdreq_last) next_state = ST_EMPTY;
      end
      default: next_state = ST_EMPTY;
    endcase
    if (flush_start) begin
      next_state = ST_FLUSH;
      valid_next = 1'b0;
      load       = 1'b0;
      if (state != ST_FLUSH) fifo_rdreq = 1'b0;
    end
  end

endmodule

// File: rtl/nios2_subsystem_fifo_read_ctrl.sv
// rtl/nios2_subsystem_fifo_read_ctrl.sv - Avalon-MM slave sequencing audio FIFO reads for the Nios II
// Register file, sticky status, saturating drop counter and level-threshold interrupt.
module nios2_subsystem_fifo_read_ctrl
  import nios2_subsystem_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int USEDW_W    = 9,
  parameter int DROP_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  input  logic [DATA_W-1:0]  fifo_q,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_wrreq,
  output logic               fifo_rdreq
);

  logic                  rd, wr, rd_data;
  logic                  flush_start, underrun_set, overflow_set, status_clr;
  logic                  underrun, overflow, irq_en;
  logic [15:0]           thresh;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic [DATA_W-1:0]     prefetch;
  logic                  valid;
  pf_state_t             state;
  logic [USEDW_W:0]      level;
  logic                  thresh_hit;
  logic [31:0]           status_word, control_word;
  logic                  unused_wdata;

  assign rd           = chipselect && read;
  assign wr           = chipselect && write;
  assign rd_data      = rd && (address == ADDR_DATA);
  assign flush_start  = wr && (address == ADDR_CONTROL) && writedata[CTL_FLUSH_BIT];
  assign underrun_set = rd_data && (state != ST_VALID);
  assign overflow_set = fifo_wrreq && fifo_full;
  assign status_clr   = wr && (address == ADDR_STATUS);
  assign unused_wdata = ^{writedata[15:5], writedata[2]};

  // The prefetched word is still a sample the CPU has not consumed
  assign level      = {1'b0, fifo_usedw} + {{USEDW_W{1'b0}}, valid};
  assign thresh_hit = (thresh != 16'd0) && (32'(level) >= 32'(thresh));

  always_comb begin
    status_word                    = '0;
    status_word[STAT_VALID_BIT]    = valid;
    status_word[STAT_EMPTY_BIT]    = fifo_empty;
    status_word[STAT_FULL_BIT]     = fifo_full;
    status_word[STAT_UNDERRUN_BIT] = underrun;
    status_word[STAT_OVERFLOW_BIT] = overflow;
    status_word[STAT_FLUSH_BIT]    = (state == ST_FLUSH);
    status_word[31:STAT_USEDW_LSB] = 16'(fifo_usedw);
    control_word                   = '0;
    control_word[CTL_IRQ_EN_BIT]   = irq_en;
    control_word[31:CTL_THRESH_LSB] = thresh;
  end

  nios2_subsystem_fifo_prefetch #(.DATA_W(DATA_W)) u_prefetch (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_q      (fifo_q),
    .fifo_empty  (fifo_empty),
    .data_read   (rd_data),
    .flush_start (flush_start),
    .fifo_rdreq  (fifo_rdreq),
    .prefetch    (prefetch),
    .valid       (valid),
    .state       (state)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      irq_en   <= 1'b0;
      thresh   <= '0;
    end else begin
      if (rd) begin
        case (address)
          ADDR_DATA:    readdata <= (state == ST_VALID) ? 32'(prefetch) : 32'd0;
          ADDR_STATUS:  readdata <= status_word;
          ADDR_CONTROL: readdata <= control_word;
          default:      readdata <= 32'(drop_cnt);
        endcase
      end
      underrun <= underrun_set || (underrun && !(status_clr && writedata[STAT_UNDERRUN_BIT]));
      overflow <= overflow_set || (overflow && !(status_clr && writedata[STAT_OVERFLOW_BIT]));
      if (wr && (address == ADDR_DROP))
        drop_cnt <= {{(DROP_CNT_W-1){1'b0}}, overflow_set};
      else if (overflow_set && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
      if (wr && (address == ADDR_CONTROL)) begin
        irq_en <= writedata[CTL_IRQ_EN_BIT];
        thresh <= writedata[31:CTL_THRESH_LSB];
      end
      irq <= irq_en && (thresh_hit || overflow);
    end
  end

endmodule
